// File: rtl/irq_priority_latch_if.sv
// irq_priority_latch_if: request/mask inputs and ID handshake between interrupt sources and the ID consumer
interface irq_priority_latch_if;
    logic [7:0] req_in;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic [2:0] id_out;
    logic       id_valid;
    logic       id_ready;
    logic [7:0] pending;
    logic [7:0] overflow;
    modport master (output req_in, mask_wr, mask_in, id_ready, input id_out, id_valid, pending, overflow);
    modport slave (input req_in, mask_wr, mask_in, id_ready, output id_out, id_valid, pending, overflow);
endinterface

// File: rtl/irq_priority_latch.sv
// irq_priority_latch: latches 8 requests into pending bits and offers the highest unmasked index over valid/ready
// Optional lost-edge flags are enabled with the IRQ_OVERFLOW_EN macro.
module irq_priority_latch #(
    parameter logic [7:0] EDGE_SEL = 8'hFF,
    parameter logic [7:0] RST_MASK = 8'h00
) (
    input logic clk,
    input logic rst,
    irq_priority_latch_if.slave bus
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t state;
    logic [7:0] req_d, pend, mask, set, clr, eligible;
    logic [2:0] id_q, hi;
    logic valid_q, accept;
    assign set = bus.req_in & ~(req_d & EDGE_SEL);
    assign accept = valid_q && bus.id_ready;
    assign clr = accept ? 8'h01 << id_q : 8'h00;
    assign eligible = pend & ~mask;
    assign bus.id_out = id_q;
    assign bus.id_valid = valid_q;
    assign bus.pending = pend;
    always_comb begin
        hi = 3'd0;
        for (int i = 0; i < 8; i++) if (eligible[i]) hi = 3'(i);
    end
    // offered ID is frozen in OFFER; new requests and mask changes wait for the next IDLE pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d <= '0;
            pend <= '0;
            mask <= RST_MASK;
            id_q <= '0;
            valid_q <= 1'b0;
            state <= IDLE;
        end else begin
            req_d <= bus.req_in;
            pend <= (pend & ~clr) | set;
            if (bus.mask_wr) mask <= bus.mask_in;
            if (state == IDLE) begin
                if (|eligible) begin
                    id_q <= hi;
                    valid_q <= 1'b1;
                    state <= OFFER;
                end
            end else if (accept) begin
                valid_q <= 1'b0;
                state <= IDLE;
            end
        end
    end
`ifdef IRQ_OVERFLOW_EN
    logic [7:0] ovf;
    always_ff @(posedge clk or posedge rst)
        if (rst) ovf <= '0;
        else ovf <= ovf | (set & EDGE_SEL & pend & ~clr);
    assign bus.overflow = ovf;
`else
    assign bus.overflow = 8'h00;
`endif
endmodule

// File: tb/tb_irq_priority_latch.sv
// tb_irq_priority_latch: directed scoreboard bench; bit 3 runs in level mode, all others edge mode
module tb_irq_priority_latch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];
    irq_priority_latch_if bus();
    irq_priority_latch #(.EDGE_SEL(8'hF7), .RST_MASK(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_q(input string name, input int target);
        int k = 0;
        while (exp_q.size() > target && k < 40) begin
            tick();
            k++;
        end
        check(name, 8'(exp_q.size()), 8'(target));
    endtask
    // every accepted ID must be the next one the stimulus predicted
    always @(negedge clk) begin
        if (!rst && bus.id_valid && bus.id_ready) begin
            if (exp_q.size() == 0) check("unexpected_id", {5'd0, bus.id_out}, 8'hEE);
            else check("accepted_id", {5'd0, bus.id_out}, {5'd0, exp_q.pop_front()});
        end
    end
    initial begin
        bus.req_in = 8'h00;
        bus.mask_wr = 1'b0;
        bus.mask_in = 8'h00;
        bus.id_ready = 1'b0;
        tick();
        tick();
        check("rst_pending", bus.pending, 8'h00);
        check("rst_valid", {7'd0, bus.id_valid}, 8'h00);
        check("rst_id", {5'd0, bus.id_out}, 8'h00);
        check("rst_overflow", bus.overflow, 8'h00);
        rst = 1'b0;
        tick();
        // single edge on bit 4
        bus.id_ready = 1'b1;
        exp_q.push_back(3'd4);
        bus.req_in = 8'h10;
        tick();
        check("edge_pending", bus.pending, 8'h10);
        check("edge_valid_early", {7'd0, bus.id_valid}, 8'h00);
        tick();
        check("edge_valid", {7'd0, bus.id_valid}, 8'h01);
        check("edge_id", {5'd0, bus.id_out}, 8'h04);
        tick();
        check("edge_cleared", bus.pending, 8'h00);
        check("edge_bubble", {7'd0, bus.id_valid}, 8'h00);
        bus.req_in = 8'h00;
        wait_q("edge_drain", 0);
        // priority without preemption
        bus.id_ready = 1'b0;
        bus.req_in = 8'h05;
        tick();
        bus.req_in = 8'h00;
        tick();
        check("prio_id", {5'd0, bus.id_out}, 8'h02);
        bus.req_in = 8'h80;
        tick();
        bus.req_in = 8'h00;
        tick();
        check("nopreempt_id", {5'd0, bus.id_out}, 8'h02);
        check("nopreempt_pend", bus.pending, 8'h85);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        bus.id_ready = 1'b1;
        wait_q("prio_drain", 0);
        tick();
        check("prio_pend_empty", bus.pending, 8'h00);
        // mask bit 7
        bus.id_ready = 1'b0;
        bus.mask_wr = 1'b1;
        bus.mask_in = 8'h80;
        tick();
        bus.mask_wr = 1'b0;
        bus.req_in = 8'h81;
        tick();
        bus.req_in = 8'h00;
        tick();
        check("mask_id", {5'd0, bus.id_out}, 8'h00);
        exp_q.push_back(3'd0);
        bus.id_ready = 1'b1;
        repeat (5) tick();
        check("mask_pend", bus.pending, 8'h80);
        check("mask_idle", {7'd0, bus.id_valid}, 8'h00);
        exp_q.push_back(3'd7);
        bus.mask_wr = 1'b1;
        bus.mask_in = 8'h00;
        tick();
        bus.mask_wr = 1'b0;
        wait_q("unmask_drain", 0);
        // level bit 3 collides set with clear
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        bus.req_in = 8'h08;
        wait_q("level_first", 1);
        check("level_set_wins", bus.pending, 8'h08);
        check("level_bubble", {7'd0, bus.id_valid}, 8'h00);
        wait_q("level_second", 0);
        bus.req_in = 8'h00;
        exp_q.push_back(3'd3);
        wait_q("level_third", 0);
        tick();
        check("level_pend_empty", bus.pending, 8'h00);
        // second edge on bit 1 while still pending
        bus.id_ready = 1'b0;
        bus.req_in = 8'h02;
        tick();
        bus.req_in = 8'h00;
        tick();
        bus.req_in = 8'h02;
        tick();
        bus.req_in = 8'h00;
        tick();
`ifdef IRQ_OVERFLOW_EN
        check("ovf_set", bus.overflow, 8'h02);
`else
        check("ovf_off", bus.overflow, 8'h00);
`endif
        exp_q.push_back(3'd1);
        bus.id_ready = 1'b1;
        wait_q("ovf_drain", 0);
        tick();
`ifdef IRQ_OVERFLOW_EN
        check("ovf_sticky", bus.overflow, 8'h02);
`else
        check("ovf_off_sticky", bus.overflow, 8'h00);
`endif
        // reset while an offer is outstanding
        bus.id_ready = 1'b0;
        bus.req_in = 8'h40;
        tick();
        bus.req_in = 8'h00;
        tick();
        check("pre_rst_valid", {7'd0, bus.id_valid}, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("async_valid", {7'd0, bus.id_valid}, 8'h00);
        check("async_pending", bus.pending, 8'h00);
        check("async_id", {5'd0, bus.id_out}, 8'h00);
        check("async_overflow", bus.overflow, 8'h00);
        tick();
        check("final_queue", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
